dcache_mshr: RTL

DCACHE_MSHR -- requirements
Module: dcache_mshr

---
 rtl/dcache_mshr_pkg.sv | 26 ++
 rtl/sys_defs_pkg.sv | 16 +
 rtl/dcache_mshr_lowest_one_enc.sv | 16 +
 rtl/dcache_mshr.sv | 103 ++++++++++
 4 files changed

// File: rtl/dcache_mshr_pkg.sv
// dcache_mshr_pkg: shared dcache miss-tracking types
// Types : MSHR_STATE (INVALID / WAIT_ISSUE / WAIT_DATA), MSHR_ENTRY (state, blk_addr, mem_tag, squashed)
// Consts: MEM_TAG_W (memory tag width), ENTRY_RST (entry reset value)
// Func  : blk_align (clears the byte-offset bits of an address)
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif
package dcache_mshr_pkg;
   localparam int MEM_TAG_W = $clog2(`NUM_MEM_TAGS);
   typedef enum logic [1:0] {
      INVALID    = 2'h0,
      WAIT_ISSUE = 2'h1,
      WAIT_DATA  = 2'h2
   } MSHR_STATE;
   // blk_addr is kept block-aligned at full width so it can drive address outputs directly
   typedef struct packed {
      MSHR_STATE              state;
      logic [31:0]            blk_addr;
      logic [MEM_TAG_W-1:0]   mem_tag;
      logic                   squashed;
   } MSHR_ENTRY;
   localparam MSHR_ENTRY ENTRY_RST = '{state: INVALID, blk_addr: 32'h0, mem_tag: '0, squashed: 1'b0};
   function automatic logic [31:0] blk_align(input logic [31:0] a, input int off_w);
      return a & ~((32'h1 << off_w) - 32'h1);
   endfunction
endpackage

// File: rtl/sys_defs_pkg.sv
// sys_defs_pkg: system-wide memory bus definitions shared by the cache and memory models
// Macros: NUM_MEM_TAGS (memory tag count, tag 0 is reserved), DATA_SIZE (bus block width in bits)
// Types : BUS_COMMAND (BUS_NONE / BUS_LOAD / BUS_STORE)
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
package sys_defs_pkg;
   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;
endpackage

// File: rtl/dcache_mshr_lowest_one_enc.sv
// lowest_one_enc: priority encoder returning the index of the lowest set bit
// Ports: vec_i (request vector), idx_o (lowest set index, 0 when none), found_o (any bit set)
module lowest_one_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0]         vec_i,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 found_o
);
   localparam int W = $clog2(N);
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) if (vec_i[i]) idx_o = W'(i);
   end
   assign found_o = |vec_i;
endmodule

// File: rtl/dcache_mshr.sv
// dcache_mshr: miss status holding registers tracking outstanding dcache block misses
// Ports: clock/reset (sync active-high), rollback (squash speculative misses),
//        miss_valid/miss_addr -> miss_ready/miss_merged/miss_idx (miss acceptance),
//        proc2mem_command/proc2mem_addr <- mem2proc_response (load issue),
//        mem2proc_data/mem2proc_tag -> fill_valid/fill_addr/fill_data/fill_idx (block return),
//        mshr_count/mshr_empty (registered occupancy)
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
module dcache_mshr
   import sys_defs_pkg::*;
   import dcache_mshr_pkg::*;
#(
   parameter int NUM_MSHR  = 4,
   parameter int BLK_OFF_W = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          rollback,
   input  logic                          miss_valid,
   input  logic [31:0]                   miss_addr,
   output logic                          miss_ready,
   output logic                          miss_merged,
   output logic [$clog2(NUM_MSHR)-1:0]   miss_idx,
   output BUS_COMMAND                    proc2mem_command,
   output logic [31:0]                   proc2mem_addr,
   input  logic [MEM_TAG_W-1:0]          mem2proc_response,
   input  logic [`DATA_SIZE-1:0]         mem2proc_data,
   input  logic [MEM_TAG_W-1:0]          mem2proc_tag,
   output logic                          fill_valid,
   output logic [31:0]                   fill_addr,
   output logic [`DATA_SIZE-1:0]         fill_data,
   output logic [$clog2(NUM_MSHR)-1:0]   fill_idx,
   output logic [$clog2(NUM_MSHR):0]     mshr_count,
   output logic                          mshr_empty
);
   localparam int IW = $clog2(NUM_MSHR);
   MSHR_ENTRY entry_q [NUM_MSHR];
   MSHR_ENTRY entry_d [NUM_MSHR];
   logic [NUM_MSHR-1:0] inv_v, wi_v, hit_v, tag_v;
   logic [IW-1:0] alloc_idx, issue_idx, hit_idx, tag_idx;
   logic alloc_ok, issue_ok, hit_ok, tag_ok;
   logic issue_go, accept, take, alloc;
   logic [31:0] miss_blk;
   assign miss_blk = blk_align(miss_addr, BLK_OFF_W);
   for (genvar g = 0; g < NUM_MSHR; g++) begin : g_vec
      assign inv_v[g] = entry_q[g].state == INVALID;
      assign wi_v[g]  = entry_q[g].state == WAIT_ISSUE;
      // squashed entries belong to a discarded path, so they never absorb new misses
      assign hit_v[g] = entry_q[g].state != INVALID && !entry_q[g].squashed && entry_q[g].blk_addr == miss_blk;
      // only WAIT_DATA entries own a tag, so an entry accepted this cycle cannot match
      assign tag_v[g] = mem2proc_tag != '0 && entry_q[g].state == WAIT_DATA && entry_q[g].mem_tag == mem2proc_tag;
   end
   lowest_one_enc #(.N(NUM_MSHR)) u_alloc (.vec_i(inv_v), .idx_o(alloc_idx), .found_o(alloc_ok));
   lowest_one_enc #(.N(NUM_MSHR)) u_issue (.vec_i(wi_v),  .idx_o(issue_idx), .found_o(issue_ok));
   lowest_one_enc #(.N(NUM_MSHR)) u_hit   (.vec_i(hit_v), .idx_o(hit_idx),   .found_o(hit_ok));
   lowest_one_enc #(.N(NUM_MSHR)) u_tag   (.vec_i(tag_v), .idx_o(tag_idx),   .found_o(tag_ok));
   assign issue_go         = issue_ok && !reset;
   assign accept           = issue_go && mem2proc_response != '0;
   assign proc2mem_command = issue_go ? BUS_LOAD : BUS_NONE;
   assign proc2mem_addr    = issue_go ? entry_q[issue_idx].blk_addr : 32'h0;
   assign fill_valid       = tag_ok && !entry_q[tag_idx].squashed && !reset;
   assign fill_addr        = fill_valid ? entry_q[tag_idx].blk_addr : 32'h0;
   assign fill_data        = fill_valid ? mem2proc_data : '0;
   assign fill_idx         = fill_valid ? tag_idx : '0;
   // a merge into an entry retiring this cycle is refused so the cache retries and hits the fill
   assign take        = miss_valid && !rollback && !reset;
   assign miss_merged = take && hit_ok && !tag_v[hit_idx];
   assign alloc       = take && !hit_ok && alloc_ok;
   assign miss_ready  = miss_merged || alloc;
   assign miss_idx    = miss_merged ? hit_idx : alloc ? alloc_idx : '0;
   always_comb begin
      for (int i = 0; i < NUM_MSHR; i++) begin
         entry_d[i] = entry_q[i];
         if (rollback && entry_q[i].state == WAIT_DATA) entry_d[i].squashed = 1'b1;
         if (accept && issue_idx == IW'(i)) begin
            entry_d[i].state    = WAIT_DATA;
            entry_d[i].mem_tag  = mem2proc_response;
            entry_d[i].squashed = rollback;
         end else if (rollback && entry_q[i].state == WAIT_ISSUE) begin
            entry_d[i] = ENTRY_RST;
         end
         if (tag_v[i]) entry_d[i] = ENTRY_RST;
         if (alloc && alloc_idx == IW'(i)) begin
            entry_d[i].state    = WAIT_ISSUE;
            entry_d[i].blk_addr = miss_blk;
            entry_d[i].mem_tag  = '0;
            entry_d[i].squashed = 1'b0;
         end
      end
   end
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_MSHR; i++) entry_q[i] <= reset ? ENTRY_RST : entry_d[i];
   end
   always_comb begin
      mshr_count = '0;
      for (int i = 0; i < NUM_MSHR; i++) mshr_count = mshr_count + {{IW{1'b0}}, ~inv_v[i]};
   end
   assign mshr_empty = mshr_count == '0;
endmodule
